conv_pool_stream: RTL and testbench
===================================

// Module: conv_pool_stream
// PURPOSE
// - Parametrised 2x2/stride-2 pooling stage with integrated output FIFO, sitting between a convolution stage and the DMA/stream sink.
// - Accepts convolved pixels in raster order and emits one pooled pixel per 2x2 window.
// - Pooling mode (max or average), data width, image size and FIFO depth are parameters.
// - Raises prog-full backpressure and a one-cycle end-of-frame interrupt.
// PARAMETERS
// - DATA_W      24   pixel width, signed two's complement
// - IMG_W       510  input pixels per row; must be even, >= 2
// - IMG_H       510  input rows per frame; must be even, >= 2
// - MODE        0    0 = max, 1 = average (floor)
// - FIFO_DEPTH  32   output FIFO entries; power of 2
// - PROG_FULL   24   level at which input ready deasserts; must be <= FIFO_DEPTH-2
// PORTS
// - axi_clk         in   1                    clock, all logic rising-edge
// - axi_reset       in   1                    synchronous, active-high reset
// - i_data_valid    in   1                    input pixel valid
// - i_data          in   DATA_W               input pixel (signed)
// - o_data_ready    out  1                    input ready = (fifo_level < PROG_FULL)
// - o_data_valid    out  1                    output FIFO head valid
// - o_pool_data     out  DATA_W               pooled pixel (signed)
// - i_data_ready    in   1                    downstream ready
// - o_intr          out  1                    one-cycle end-of-frame pulse
// - o_fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset values: o_data_valid=0, o_intr=0, o_fifo_level=0, o_data_ready=1.
// - Reset clears counters, FSM, line buffer valid state and FIFO.
// - Reset mid-frame discards all partial windows; the next accepted pixel is pixel (0,0).
// - Accept: i_data_valid && o_data_ready. Input is ignored when not accepted.
// - Counters: col 0..IMG_W-1 and row 0..IMG_H-1. Both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
// - FSM states:
//   - S_EVEN_ROW: pixel pair -> hpart = combine(p0, p1), written to line buffer[col/2] on the 2nd pixel.
//   - S_ODD_ROW: pixel pair -> result = combine(linebuf[col/2], hpart), pushed to FIFO.
//   - Transitions: S_EVEN_ROW -> S_ODD_ROW at col wrap on an even row; S_ODD_ROW -> S_EVEN_ROW at col wrap.
//   - A phase bit (col[0]) holds the first pixel of each pair.
// - Line buffer: IMG_W/2 entries, DATA_W+1 bits; extra bit is for average mode.
// - Max mode: signed compare; ties are irrelevant.
// - Average mode:
//   - Sum of 4 pixels in DATA_W+2 bits.
//   - Arithmetic shift right by 2 (floor toward -inf); result fits DATA_W exactly.
// - Latency:
//   - FIFO write occurs the cycle after the 4th window pixel is accepted.
//   - o_data_valid rises the cycle after that write (first-word-fall-through from an empty FIFO).
// - Output handshake:
//   - Pop on o_data_valid && i_data_ready.
//   - o_pool_data is stable while o_data_valid && !i_data_ready.
// - Simultaneous push and pop: level unchanged; legal at any level, including full.
// - PROG_FULL <= FIFO_DEPTH-2 guarantees the in-flight push never overflows; no data is ever dropped.
// - o_intr: asserted the cycle the final pooled pixel of a frame is written to the FIFO, for exactly 1 cycle.
// - Back-to-back frames need no idle gap.
// STRUCTURE
// - Package conv_pool_pkg:
//   - pool_mode_e {POOL_MAX, POOL_AVG}
//   - pool_state_e {S_EVEN_ROW, S_ODD_ROW}
//   - function pool_combine(mode, a, b)
// - Sub-module stream_fifo: synchronous FWFT FIFO with level output; parameters DATA_W and DEPTH.
// - Line buffer is an inferred RAM inline in the block, not a separate module.
// TESTING
// - Common setup for tests 1-4: DATA_W=8, IMG_W=4, IMG_H=4.
// - Max mode, frame 0..15 raster, ready=1 -> outputs 5,7,13,15 in order; one o_intr pulse coincident with the write of 15.
// - Average mode:
//   - Same frame -> outputs 2,4,10,12.
//   - Window {-1,-2,-3,-4} -> -3 (floor of -2.5).
//   - Window {127,127,127,127} -> 127.
// - Backpressure: i_data_ready=0, FIFO_DEPTH=8, PROG_FULL=6.
//   - Expect o_data_ready=0 from the cycle after level reaches 6, and level never exceeds 8.
//   - Release ready -> all queued results are delivered in order with no loss.
// - Reset mid-frame: pulse axi_reset after 6 pixels, then send a full frame of 0..15 -> exactly 4 outputs 5,7,13,15; no stale result.
// - Random i_data_valid/i_data_ready (50% duty), 3 back-to-back frames, both modes, IMG_W=6, IMG_H=4 -> output stream matches reference model; exactly 3 o_intr pulses.

Source files
------------

// File: rtl/conv_pool_pkg.sv
// Shared types and the pooling combine operator used by conv_pool_stream.
// The operator is width-agnostic: callers sign-extend into comb_t and truncate the result.
package conv_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    S_EVEN_ROW = 1'b0,
    S_ODD_ROW  = 1'b1
  } pool_state_e;

  // Wide enough for any practical pixel width plus the two average-mode growth bits.
  localparam int COMB_W = 64;

  typedef logic signed [COMB_W-1:0] comb_t;

  // Max keeps the larger operand; average accumulates and leaves the final shift to the caller.
  function automatic comb_t pool_combine(input pool_mode_e mode, input comb_t a, input comb_t b);
    if (mode == POOL_AVG) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A push and a pop in the same cycle are always legal, even when full.
module stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = i_pop && (r_level != '0);
  assign w_push = i_push && (!w_full || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the level counter alone decides what is readable.
  always_ff @(posedge axi_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = (r_level != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/conv_pool_stream.sv
// 2x2 stride-2 max/average pooling over a raster pixel stream; pooled pixels are queued
// in an output FIFO whose programmable-full level throttles the input.
module conv_pool_stream
  import conv_pool_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int IMG_W      = 510,
  parameter int IMG_H      = 510,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 32,
  parameter int PROG_FULL  = 24
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic                        i_data_valid,
  input  logic signed [DATA_W-1:0]    i_data,
  output logic                        o_data_ready,
  output logic                        o_data_valid,
  output logic signed [DATA_W-1:0]    o_pool_data,
  input  logic                        i_data_ready,
  output logic                        o_intr,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam pool_mode_e P_MODE = (MODE == 1) ? POOL_AVG : POOL_MAX;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef logic signed [DATA_W:0]   hpart_t;
  typedef logic signed [DATA_W+1:0] quad_t;

  pool_state_e r_state;
  pool_state_e w_state_nxt;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pix_t             r_p0;
  hpart_t           r_linebuf [LB_DEPTH];
  logic             r_push;
  pix_t             r_push_data;
  logic             r_intr;

  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_pair_done;
  logic             w_lb_we;
  logic             w_push_nxt;
  logic [LB_AW-1:0] w_lb_addr;
  hpart_t           w_hpart;
  hpart_t           w_lb_rd;
  quad_t            w_quad;
  pix_t             w_result;

  assign w_accept    = i_data_valid && o_data_ready;
  assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));
  assign w_pair_done = w_accept && r_col[0];
  assign w_lb_addr   = LB_AW'(r_col >> 1);

  // Horizontal pair is combined first; the odd row merges it with the stored even-row pair.
  assign w_hpart  = hpart_t'(pool_combine(P_MODE, comb_t'(r_p0), comb_t'(i_data)));
  assign w_lb_rd  = r_linebuf[w_lb_addr];
  assign w_quad   = quad_t'(pool_combine(P_MODE, comb_t'(w_lb_rd), comb_t'(w_hpart)));
  assign w_result = (P_MODE == POOL_AVG) ? pix_t'(w_quad >>> 2) : pix_t'(w_quad);

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state <= S_EVEN_ROW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_lb_we     = 1'b0;
    w_push_nxt  = 1'b0;
    if (w_pair_done) begin
      case (r_state)
        S_EVEN_ROW: w_lb_we    = 1'b1;
        S_ODD_ROW:  w_push_nxt = 1'b1;
      endcase
    end
    if (w_accept && w_col_last) begin
      w_state_nxt = (r_state == S_EVEN_ROW) ? S_ODD_ROW : S_EVEN_ROW;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_p0        <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_intr      <= 1'b0;
    end else begin
      r_push <= w_push_nxt;
      r_intr <= w_push_nxt && w_col_last && w_row_last;
      if (w_push_nxt) r_push_data <= w_result;
      if (w_accept) begin
        if (!r_col[0]) r_p0 <= i_data;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  // Even-row results are only read after the same frame rewrote them, so stale contents are harmless.
  always_ff @(posedge axi_clk) begin
    if (w_lb_we) r_linebuf[w_lb_addr] <= w_hpart;
  end

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (i_data_ready),
    .o_valid     (o_data_valid),
    .o_data      (o_pool_data),
    .o_level     (o_fifo_level)
  );

  assign o_intr       = r_intr;
  assign o_data_ready = (o_fifo_level < LVL_W'(PROG_FULL));

endmodule

// File: tb/tb_conv_pool_stream.sv
// Directed bench for conv_pool_stream: four instances cover max/average on 4x4 and 6x4 frames,
// with FIFO_DEPTH=8 and PROG_FULL=6 throughout.
module tb_conv_pool_stream;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              vld    [N];
  logic signed [7:0] din    [N];
  logic              rdy_in [N];
  wire               o_rdy  [N];
  wire               o_vld  [N];
  wire signed [7:0]  o_dat  [N];
  wire               o_intr [N];
  wire [3:0]         lvl    [N];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int                got_n    [N];
  logic signed [7:0] got_d    [N][64];
  int                got_c    [N][64];
  int                intr_n   [N];
  int                intr_c   [N];
  int                last_acc [N];
  logic              stall_p  [N];
  logic signed [7:0] stall_d  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    conv_pool_stream #(
      .DATA_W     (8),
      .IMG_W      ((g < 2) ? 4 : 6),
      .IMG_H      (4),
      .MODE       (g % 2),
      .FIFO_DEPTH (8),
      .PROG_FULL  (6)
    ) u_dut (
      .axi_clk      (clk),
      .axi_reset    (rst),
      .i_data_valid (vld[g]),
      .i_data       (din[g]),
      .o_data_ready (o_rdy[g]),
      .o_data_valid (o_vld[g]),
      .o_pool_data  (o_dat[g]),
      .i_data_ready (rdy_in[g]),
      .o_intr       (o_intr[g]),
      .o_fifo_level (lvl[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor: records pops and interrupts, checks level/ready and hold-while-stalled.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!rst) begin
        n_checks++;
        if (lvl[g] > 4'd8 || o_rdy[g] !== (lvl[g] < 4'd6)) begin
          n_errors++;
          $display("FAIL level_ready inst %0d: level=%0d ready=%b, required level<=8 and ready=%b",
                   g, lvl[g], o_rdy[g], (lvl[g] < 4'd6));
        end
        if (stall_p[g] && o_vld[g]) begin
          n_checks++;
          if (o_dat[g] !== stall_d[g]) begin
            n_errors++;
            $display("FAIL hold_stable inst %0d: data=%0d, required %0d", g, o_dat[g], stall_d[g]);
          end
        end
        if (o_vld[g] && rdy_in[g] && got_n[g] < 64) begin
          got_d[g][got_n[g]] = o_dat[g];
          got_c[g][got_n[g]] = cyc;
          got_n[g]++;
        end
        if (o_intr[g]) begin
          intr_n[g]++;
          intr_c[g] = cyc;
        end
      end
      stall_p[g] = o_vld[g] && !rdy_in[g] && !rst;
      stall_d[g] = o_dat[g];
    end
  end

  task automatic clear_rec(input int g);
    got_n[g]  = 0;
    intr_n[g] = 0;
    intr_c[g] = -1;
  endtask

  task automatic send_pixel(input int g, input int val, input bit rnd);
    bit done = 1'b0;
    int budget = 0;
    din[g] = 8'(val);
    while (!done) begin
      vld[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) rdy_in[g] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (vld[g] && o_rdy[g]) begin
        done = 1'b1;
        last_acc[g] = cyc;
      end
      @(posedge clk);
      #1;
      budget++;
      if (!done && budget > 400) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout inst %0d: pixel %0d not accepted within 400 cycles", g, val);
        done = 1'b1;
      end
    end
    vld[g] = 1'b0;
  endtask

  task automatic send_vals(input int g, input int q[$], input bit rnd);
    foreach (q[i]) send_pixel(g, q[i], rnd);
  endtask

  task automatic wait_outputs(input int g, input int n, input string tag);
    int budget = 0;
    while (got_n[g] < n && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (got_n[g] !== n) begin
      n_errors++;
      $display("FAIL %s_count: got %0d outputs, required %0d", tag, got_n[g], n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      n_checks += 4;
      if (o_vld[g] !== 1'b0) begin n_errors++; $display("FAIL reset_valid inst %0d: %b, required 0", g, o_vld[g]); end
      if (o_intr[g] !== 1'b0) begin n_errors++; $display("FAIL reset_intr inst %0d: %b, required 0", g, o_intr[g]); end
      if (lvl[g] !== 4'd0) begin n_errors++; $display("FAIL reset_level inst %0d: %0d, required 0", g, lvl[g]); end
      if (o_rdy[g] !== 1'b1) begin n_errors++; $display("FAIL reset_ready inst %0d: %b, required 1", g, o_rdy[g]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_max_frame();
    int q[$];
    logic signed [7:0] exp_v [4] = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
    clear_rec(0);
    rdy_in[0] = 1'b1;
    for (int i = 0; i < 16; i++) q.push_back(i);
    send_vals(0, q, 1'b0);
    wait_outputs(0, 4, "max");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[0][i] !== exp_v[i]) begin
        n_errors++;
        $display("FAIL max_out[%0d]: got %0d, required %0d", i, got_d[0][i], exp_v[i]);
      end
    end
    n_checks += 3;
    if (intr_n[0] !== 1) begin n_errors++; $display("FAIL max_intr_count: got %0d, required 1", intr_n[0]); end
    if (intr_c[0] !== last_acc[0] + 1) begin
      n_errors++;
      $display("FAIL max_intr_timing: intr at cycle %0d, required %0d", intr_c[0], last_acc[0] + 1);
    end
    if (got_c[0][3] !== intr_c[0] + 1) begin
      n_errors++;
      $display("FAIL max_valid_latency: last output at cycle %0d, required %0d", got_c[0][3], intr_c[0] + 1);
    end
  endtask

  task automatic test_avg_frames();
    int q[$];
    int special[16] = '{-1, -2, 127, 127, -3, -4, 127, 127, -128, -128, 127, 127, -128, -128, 127, 126};
    logic signed [7:0] exp_v [8] = '{8'sd2, 8'sd4, 8'sd10, 8'sd12, -8'sd3, 8'sd127, -8'sd128, 8'sd126};
    clear_rec(1);
    rdy_in[1] = 1'b1;
    for (int i = 0; i < 16; i++) q.push_back(i);
    for (int i = 0; i < 16; i++) q.push_back(special[i]);
    send_vals(1, q, 1'b0);
    wait_outputs(1, 8, "avg");
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_d[1][i] !== exp_v[i]) begin
        n_errors++;
        $display("FAIL avg_out[%0d]: got %0d, required %0d", i, got_d[1][i], exp_v[i]);
      end
    end
    n_checks++;
    if (intr_n[1] !== 2) begin n_errors++; $display("FAIL avg_intr_count: got %0d, required 2", intr_n[1]); end
  endtask

  task automatic test_backpressure();
    int q[$];
    clear_rec(0);
    rdy_in[0] = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 16; i++) q.push_back(16 * f + i);
    fork
      send_vals(0, q, 1'b0);
      begin
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (lvl[0] !== 4'd6) begin n_errors++; $display("FAIL bp_level: %0d, required 6", lvl[0]); end
        if (o_rdy[0] !== 1'b0) begin n_errors++; $display("FAIL bp_ready: %b, required 0", o_rdy[0]); end
        if (o_vld[0] !== 1'b1) begin n_errors++; $display("FAIL bp_valid: %b, required 1", o_vld[0]); end
        if (got_n[0] !== 0) begin n_errors++; $display("FAIL bp_no_pop: %0d pops, required 0", got_n[0]); end
        @(posedge clk);
        #1 rdy_in[0] = 1'b1;
      end
    join
    wait_outputs(0, 12, "bp");
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        int base[4] = '{5, 7, 13, 15};
        n_checks++;
        if (got_d[0][4 * f + k] !== 8'(base[k] + 16 * f)) begin
          n_errors++;
          $display("FAIL bp_out[%0d]: got %0d, required %0d", 4 * f + k, got_d[0][4 * f + k], base[k] + 16 * f);
        end
      end
    end
    n_checks++;
    if (intr_n[0] !== 3) begin n_errors++; $display("FAIL bp_intr_count: got %0d, required 3", intr_n[0]); end
  endtask

  task automatic test_reset_midframe();
    int q[$];
    int p[$];
    logic signed [7:0] exp_v [4] = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 6; i++) p.push_back(i);
    send_vals(0, p, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (lvl[0] !== 4'd1) begin n_errors++; $display("FAIL mid_stale_level: %0d, required 1", lvl[0]); end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (lvl[0] !== 4'd0) begin n_errors++; $display("FAIL mid_reset_level: %0d, required 0", lvl[0]); end
    if (o_vld[0] !== 1'b0) begin n_errors++; $display("FAIL mid_reset_valid: %b, required 0", o_vld[0]); end
    @(posedge clk);
    #1;
    clear_rec(0);
    rdy_in[0] = 1'b1;
    for (int i = 0; i < 16; i++) q.push_back(i);
    send_vals(0, q, 1'b0);
    wait_outputs(0, 4, "mid");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[0][i] !== exp_v[i]) begin
        n_errors++;
        $display("FAIL mid_out[%0d]: got %0d, required %0d", i, got_d[0][i], exp_v[i]);
      end
    end
    n_checks++;
    if (intr_n[0] !== 1) begin n_errors++; $display("FAIL mid_intr_count: got %0d, required 1", intr_n[0]); end
  endtask

  task automatic test_random(input int g);
    int px[$];
    int exp_q[$];
    for (int f = 0; f < 3; f++) begin
      int base = f * 24;
      for (int i = 0; i < 24; i++) px.push_back(int'($urandom_range(0, 255)) - 128);
      for (int wr = 0; wr < 2; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          int idx = base + 12 * wr + 2 * wc;
          int a = px[idx];
          int b = px[idx + 1];
          int c = px[idx + 6];
          int d = px[idx + 7];
          int m = a;
          if (b > m) m = b;
          if (c > m) m = c;
          if (d > m) m = d;
          exp_q.push_back((g % 2 == 1) ? ((a + b + c + d) >>> 2) : m);
        end
      end
    end
    clear_rec(g);
    send_vals(g, px, 1'b1);
    rdy_in[g] = 1'b1;
    wait_outputs(g, 18, (g % 2 == 1) ? "rand_avg" : "rand_max");
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (got_d[g][i] !== 8'(exp_q[i])) begin
        n_errors++;
        $display("FAIL rand_out inst %0d [%0d]: got %0d, required %0d", g, i, got_d[g][i], exp_q[i]);
      end
    end
    n_checks++;
    if (intr_n[g] !== 3) begin n_errors++; $display("FAIL rand_intr_count inst %0d: got %0d, required 3", g, intr_n[g]); end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      vld[g]     = 1'b0;
      din[g]     = '0;
      rdy_in[g]  = 1'b1;
      stall_p[g] = 1'b0;
      stall_d[g] = '0;
      last_acc[g] = 0;
      clear_rec(g);
    end
    test_reset();
    test_max_frame();
    test_avg_frames();
    test_backpressure();
    test_reset_midframe();
    test_random(2);
    test_random(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
